// File: rtl/vm_pkg.sv
// vm_pkg: shared types and constants for the metro ticket vending machine.
//  - vm_state_e : transaction state (idle -> count -> pay -> done)
//  - coin constants and is_coin() helper for accepted coin values
//  - port widths and default configuration values
package vm_pkg;

  localparam int NUM_STATIONS_DEF = 5;
  localparam int FARE_BASE_DEF    = 5;
  localparam int MAX_TICKETS_DEF  = 7;

  localparam int STN_W  = 3;
  localparam int CNT_W  = 3;
  localparam int COIN_W = 6;
  localparam int COST_W = 6;
  localparam int PAY_W  = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PAY   = 2'd2,
    S_DONE  = 2'd3
  } vm_state_e;

  localparam logic [COIN_W-1:0] COIN_1  = 6'd1;
  localparam logic [COIN_W-1:0] COIN_5  = 6'd5;
  localparam logic [COIN_W-1:0] COIN_10 = 6'd10;
  localparam logic [COIN_W-1:0] COIN_50 = 6'd50;

  // True only for the coin denominations the machine accepts.
  function automatic logic is_coin(input logic [COIN_W-1:0] v);
    return (v == COIN_1) || (v == COIN_5) || (v == COIN_10) || (v == COIN_50);
  endfunction

endpackage

// File: rtl/vending_machine_if.sv
// vending_machine_if: front-panel inputs and dispenser outputs of the vending machine.
//  master : drives origin/destination/howmanyticket/money (and cancel), reads results
//  slave  : the machine itself
//  Optional macro VM_CANCEL_EN adds the 1-bit cancel request.
interface vending_machine_if;
  import vm_pkg::*;

  logic [STN_W-1:0]  origin;
  logic [STN_W-1:0]  destination;
  logic [CNT_W-1:0]  howmanyticket;
  logic [COIN_W-1:0] money;
`ifdef VM_CANCEL_EN
  logic              cancel;
`endif
  logic [COST_W-1:0] costofticket;
  logic [PAY_W-1:0]  moneytopay;
  logic [PAY_W-1:0]  totalmoney;
  logic [PAY_W-1:0]  change;
  logic              done;

  modport master (
    output origin, destination, howmanyticket, money,
`ifdef VM_CANCEL_EN
    output cancel,
`endif
    input  costofticket, moneytopay, totalmoney, change, done
  );

  modport slave (
    input  origin, destination, howmanyticket, money,
`ifdef VM_CANCEL_EN
    input  cancel,
`endif
    output costofticket, moneytopay, totalmoney, change, done
  );

endinterface

// File: rtl/vm_fare_calc.sv
// vm_fare_calc: combinational station check and single-ticket fare.
//  origin, destination : station codes (valid 1..NUM_STATIONS)
//  valid               : both codes in range and different
//  cost                : FARE_BASE * (|destination - origin| + 1), 0 when invalid
module vm_fare_calc
  import vm_pkg::*;
#(
  parameter int NUM_STATIONS = NUM_STATIONS_DEF,
  parameter int FARE_BASE    = FARE_BASE_DEF
) (
  input  logic [STN_W-1:0]  origin,
  input  logic [STN_W-1:0]  destination,
  output logic              valid,
  output logic [COST_W-1:0] cost
);

  localparam logic [STN_W-1:0]  MAX_STN = STN_W'(NUM_STATIONS);
  localparam logic [COST_W-1:0] BASE    = COST_W'(FARE_BASE);

  logic [STN_W-1:0] hops_s;
  logic             in_range_s;

  // Range check and fare; the product never exceeds 6 bits for up to 7 stations.
  always_comb begin
    if (origin > destination) begin
      hops_s = origin - destination;
    end else begin
      hops_s = destination - origin;
    end
    in_range_s = (origin >= 3'd1) && (origin <= MAX_STN) &&
                 (destination >= 3'd1) && (destination <= MAX_STN);
    if (in_range_s && (origin != destination)) begin
      valid = 1'b1;
      cost  = BASE * ({3'd0, hops_s} + 6'd1);
    end else begin
      valid = 1'b0;
      cost  = 6'd0;
    end
  end

endmodule

// File: rtl/vending_machine.sv
// vending_machine: metro ticket vending FSM.
//  clk   : rising-edge clock
//  reset : asynchronous active-low reset
//  bus   : vending_machine_if.slave (selection/coin inputs, fare/price/credit/change/done)
//  Optional macro VM_CANCEL_EN: cancel in S_COUNT/S_PAY refunds the credit as change.
//  All outputs come straight from registers; a transaction ends in S_DONE until reset.
module vending_machine
  import vm_pkg::*;
#(
  parameter int NUM_STATIONS = NUM_STATIONS_DEF,
  parameter int FARE_BASE    = FARE_BASE_DEF,
  parameter int MAX_TICKETS  = MAX_TICKETS_DEF
) (
  input logic               clk,
  input logic               reset,
  vending_machine_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TICKETS);

  vm_state_e         state_r;
  logic [COST_W-1:0] cost_r;
  logic [PAY_W-1:0]  pay_r;
  logic [PAY_W-1:0]  total_r;
  logic [PAY_W-1:0]  change_r;
  logic              done_r;

  logic              fare_ok_s;
  logic [COST_W-1:0] fare_s;
  logic              count_ok_s;
  logic [PAY_W-1:0]  price_s;
  logic [PAY_W-1:0]  coin_add_s;
  logic [PAY_W-1:0]  new_total_s;

  vm_fare_calc #(
    .NUM_STATIONS (NUM_STATIONS),
    .FARE_BASE    (FARE_BASE)
  ) u_fare (
    .origin      (bus.origin),
    .destination (bus.destination),
    .valid       (fare_ok_s),
    .cost        (fare_s)
  );

  // Ticket count check, total price and credit after this cycle's coin.
  always_comb begin
    count_ok_s = (bus.howmanyticket >= 3'd1) && (bus.howmanyticket <= MAX_CNT);
    price_s    = PAY_W'(cost_r) * PAY_W'(bus.howmanyticket);
    if (is_coin(bus.money)) begin
      coin_add_s = PAY_W'(bus.money);
    end else begin
      coin_add_s = 9'd0;
    end
    new_total_s = total_r + coin_add_s;
  end

  // Transaction FSM; every output is updated here so all of them are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      cost_r   <= 6'd0;
      pay_r    <= 9'd0;
      total_r  <= 9'd0;
      change_r <= 9'd0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (fare_ok_s) begin
            cost_r  <= fare_s;
            state_r <= S_COUNT;
          end
        end
        S_COUNT: begin
`ifdef VM_CANCEL_EN
          if (bus.cancel) begin
            change_r <= total_r;
            pay_r    <= 9'd0;
            state_r  <= S_DONE;
          end else
`endif
          if (count_ok_s) begin
            pay_r   <= price_s;
            state_r <= S_PAY;
          end
        end
        S_PAY: begin
`ifdef VM_CANCEL_EN
          if (bus.cancel) begin
            change_r <= total_r;
            pay_r    <= 9'd0;
            state_r  <= S_DONE;
          end else
`endif
          begin
            total_r <= new_total_s;
            // Paid-up is judged on the credit including this cycle's coin.
            if (new_total_s >= pay_r) begin
              change_r <= new_total_s - pay_r;
              done_r   <= 1'b1;
              state_r  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_r <= S_DONE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.costofticket = cost_r;
  assign bus.moneytopay   = pay_r;
  assign bus.totalmoney   = total_r;
  assign bus.change       = change_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: self-checking bench for vending_machine.
//  Table of selection vectors, hand-written multi-cycle sequences and randomized
//  transactions compared against a fare/credit model built from the pricing rules.
module tb_vending_machine;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vending_machine_if vif ();

  vending_machine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] o;
    logic [2:0] d;
    logic [2:0] n;
    int         cost;
    int         pay;
  } vec_t;

  vec_t tbl [8];
  int   legal_coins [4] = '{1, 5, 10, 50};
  int   coin_pool [9]   = '{0, 1, 5, 10, 50, 7, 3, 20, 63};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.origin        = 3'd0;
    vif.destination   = 3'd0;
    vif.howmanyticket = 3'd0;
    vif.money         = 6'd0;
`ifdef VM_CANCEL_EN
    vif.cancel        = 1'b0;
`endif
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic chk_outputs(input string name, input int cost, input int pay,
                             input int total, input int chg, input int dn);
    chk({name, ".cost"},   int'(vif.costofticket), cost);
    chk({name, ".pay"},    int'(vif.moneytopay),   pay);
    chk({name, ".total"},  int'(vif.totalmoney),   total);
    chk({name, ".change"}, int'(vif.change),       chg);
    chk({name, ".done"},   int'(vif.done),         dn);
  endtask

  function automatic int fare_of(input int o, input int d);
    int hops;
    if (o < 1 || o > 5 || d < 1 || d > 5 || o == d) return 0;
    hops = (o > d) ? o - d : d - o;
    return 5 * (hops + 1);
  endfunction

  function automatic bit coin_ok(input int c);
    foreach (legal_coins[i]) if (legal_coins[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq1 [6];
    int tot1 [6];
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();

    tbl[0] = '{3'd5, 3'd2, 3'd2, 20, 40};
    tbl[1] = '{3'd3, 3'd1, 3'd3, 15, 45};
    tbl[2] = '{3'd4, 3'd4, 3'd1, 0, 0};
    tbl[3] = '{3'd0, 3'd3, 3'd1, 0, 0};
    tbl[4] = '{3'd1, 3'd5, 3'd7, 25, 175};
    tbl[5] = '{3'd2, 3'd6, 3'd1, 0, 0};
    tbl[6] = '{3'd1, 3'd2, 3'd0, 10, 0};
    tbl[7] = '{3'd5, 3'd4, 3'd7, 10, 70};

    // Reset state
    reset_dut();
    chk_outputs("reset", 0, 0, 0, 0, 0);

    // Table: fare and price selection
    for (int i = 0; i < 8; i++) begin
      reset_dut();
      vif.origin      = tbl[i].o;
      vif.destination = tbl[i].d;
      step();
      chk($sformatf("tbl%0d.cost", i), int'(vif.costofticket), tbl[i].cost);
      vif.howmanyticket = tbl[i].n;
      step();
      chk($sformatf("tbl%0d.pay", i), int'(vif.moneytopay), tbl[i].pay);
    end

    // Sequence 1: o=5,d=2,n=2 paid with 10,10,1,5,10,10
    seq1 = '{10, 10, 1, 5, 10, 10};
    tot1 = '{10, 20, 21, 26, 36, 46};
    reset_dut();
    vif.origin = 3'd5; vif.destination = 3'd2; step();
    vif.howmanyticket = 3'd2; step();
    for (int i = 0; i < 6; i++) begin
      vif.money = 6'(seq1[i]);
      step();
      chk($sformatf("seq1.total%0d", i), int'(vif.totalmoney), tot1[i]);
      chk($sformatf("seq1.done%0d", i), int'(vif.done), (i == 5) ? 1 : 0);
    end
    chk_outputs("seq1.end", 20, 40, 46, 6, 1);
    // Frozen in done: further coins and selections are ignored
    vif.money = 6'd50; vif.origin = 3'd1; vif.destination = 3'd5; vif.howmanyticket = 3'd7;
    step(); step();
    chk_outputs("seq1.frozen", 20, 40, 46, 6, 1);

    // Sequence 2: single 50 coin overpays
    reset_dut();
    vif.origin = 3'd3; vif.destination = 3'd1; step();
    vif.howmanyticket = 3'd3; step();
    vif.money = 6'd50; step();
    chk_outputs("seq2", 15, 45, 50, 5, 1);

    // Sequence 3: invalid selections hold idle, then a valid one latches
    reset_dut();
    vif.origin = 3'd4; vif.destination = 3'd4;
    vif.howmanyticket = 3'd2;
    step(); step(); step();
    chk("seq3.same", int'(vif.costofticket), 0);
    vif.origin = 3'd0; vif.destination = 3'd3; step(); step();
    chk("seq3.zero", int'(vif.costofticket), 0);
    chk("seq3.nopay", int'(vif.moneytopay), 0);
    vif.origin = 3'd1; vif.destination = 3'd5; step();
    chk("seq3.valid", int'(vif.costofticket), 25);

    // Sequence 4/5: illegal coins ignored, held coin counts per clk, async reset mid-pay
    reset_dut();
    vif.origin = 3'd5; vif.destination = 3'd2; step();
    vif.howmanyticket = 3'd2; step();
    vif.origin = 3'd1; vif.destination = 3'd2; vif.howmanyticket = 3'd7;
    vif.money = 6'd7; step(); step(); step();
    chk("seq4.bad7", int'(vif.totalmoney), 0);
    vif.money = 6'd0; step(); step();
    chk("seq4.zero", int'(vif.totalmoney), 0);
    chk("seq4.cost_latched", int'(vif.costofticket), 20);
    chk("seq4.pay_latched", int'(vif.moneytopay), 40);
    vif.money = 6'd10; step(); step();
    vif.money = 6'd0;
    chk("seq4.held", int'(vif.totalmoney), 20);
    reset = 1'b0;
    #1;
    chk_outputs("seq5.async", 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    vif.origin = 3'd3; vif.destination = 3'd1; step();
    chk("seq5.idle_again", int'(vif.costofticket), 15);

`ifdef VM_CANCEL_EN
    // Sequence 6: cancel refunds the credit
    reset_dut();
    vif.origin = 3'd1; vif.destination = 3'd2; step();
    vif.howmanyticket = 3'd2; step();
    chk("seq6.pay", int'(vif.moneytopay), 20);
    vif.money = 6'd5; step();
    vif.money = 6'd10; vif.cancel = 1'b1; step();
    chk_outputs("seq6.cancel", 10, 0, 5, 5, 0);
    vif.cancel = 1'b0; vif.money = 6'd50; step(); step();
    chk_outputs("seq6.frozen", 10, 0, 5, 5, 0);
`endif

    // Randomized transactions against the pricing model
    for (int t = 0; t < 30; t++) begin
      int  exp_cost, exp_pay, exp_total, exp_change, exp_done;
      int  o, d, n, c;
      bit  latched;
      reset_dut();
      exp_cost = 0; exp_pay = 0; exp_total = 0; exp_change = 0; exp_done = 0;
      latched = 1'b0;
      for (int i = 0; i < 12 && !latched; i++) begin
        o = $urandom_range(0, 7);
        d = $urandom_range(0, 7);
        if (i == 11) begin o = 2; d = 4; end
        vif.origin = 3'(o); vif.destination = 3'(d);
        vif.howmanyticket = 3'($urandom_range(0, 7));
        step();
        if (fare_of(o, d) != 0) begin exp_cost = fare_of(o, d); latched = 1'b1; end
        chk("rnd.cost", int'(vif.costofticket), exp_cost);
      end
      latched = 1'b0;
      for (int i = 0; i < 12 && !latched; i++) begin
        n = $urandom_range(0, 7);
        if (i == 11) n = 3;
        vif.howmanyticket = 3'(n);
        vif.origin = 3'($urandom_range(0, 7));
        vif.destination = 3'($urandom_range(0, 7));
        vif.money = 6'($urandom_range(0, 63));
        step();
        if (n >= 1) begin exp_pay = exp_cost * n; latched = 1'b1; end
        chk("rnd.pay", int'(vif.moneytopay), exp_pay);
        chk("rnd.total0", int'(vif.totalmoney), 0);
      end
      for (int i = 0; i < 300 && exp_done == 0; i++) begin
        c = coin_pool[$urandom_range(0, 8)];
        vif.money = 6'(c);
        vif.howmanyticket = 3'($urandom_range(0, 7));
        step();
        if (coin_ok(c)) exp_total += c;
        if (exp_total >= exp_pay) begin
          exp_change = exp_total - exp_pay;
          exp_done = 1;
        end
        chk("rnd.total", int'(vif.totalmoney), exp_total);
        chk("rnd.done", int'(vif.done), exp_done);
      end
      chk("rnd.finished", exp_done, 1);
      for (int i = 0; i < 3; i++) begin
        vif.money = 6'd50;
        vif.origin = 3'($urandom_range(0, 7));
        step();
      end
      chk_outputs("rnd.final", exp_cost, exp_pay, exp_total, exp_change, exp_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
